mouse_master_sm: RTL and testbench
==================================

Name: mouse_master_sm

Overview:
- Sequences the PS/2 mouse link and owns both the byte transmitter and the byte receiver.
- After reset it runs the host initialisation: reset command 0xFF, then expects ack 0xFA, BAT pass 0xAA and device ID 0x00. It then sends enable-streaming 0xF4 and expects ack 0xFA.
- Once initialised it assembles 3-byte movement packets and presents them, with a one-cycle interrupt, to the downstream bus interface.
- A watchdog restarts initialisation whenever the device stalls.

Parameters:
- TIMEOUT_CYCLES, 100000000: watchdog limit in CLK cycles for every init state (1 s at 100 MHz); counter is 27 bits.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  synchronous, active-high reset.
- SEND_BYTE  out  1  one-cycle request to the transmitter.
- BYTE_TO_SEND  out  8  command byte; held stable from the SEND_BYTE cycle until BYTE_SENT.
- BYTE_SENT  in  1  one-cycle pulse: transmitter saw the device ack.
- READ_ENABLE  out  1  receiver enable.
- BYTE_READ  in  8  received byte; valid when BYTE_READY=1.
- BYTE_READY  in  1  one-cycle pulse: byte received.
- BYTE_ERROR_CODE  in  2  00 = ok; bit0 = parity error; bit1 = stop-bit error.
- MOUSE_STATUS  out  8  packet byte 0.
- MOUSE_DX  out  8  packet byte 1.
- MOUSE_DY  out  8  packet byte 2.
- SEND_INTERRUPT  out  1  one-cycle pulse: new packet on the MOUSE_* outputs.
- INIT_DONE  out  1  high while in the streaming states.
- RETRY_COUNT  out  4  saturating count of init restarts.
- MASTER_STATE  out  4  current state code, for debug.

Behaviour:
- **Clocking:** all outputs are registered; the FSM updates on posedge CLK; RESET has priority over everything.
- **Reset values:** SEND_BYTE=0, BYTE_TO_SEND=0x00, READ_ENABLE=0, MOUSE_STATUS/DX/DY=0x00, SEND_INTERRUPT=0, INIT_DONE=0, RETRY_COUNT=0, state=S0, watchdog=0.
- **Reset mid-transaction:** all outputs return to reset values on the next edge; the transmitter must be reset by the same RESET.
- **State list:**
  - S0 SEND_RST: SEND_BYTE=1 for exactly one cycle, BYTE_TO_SEND=0xFF -> S1.
  - S1 WAIT_RST_SENT: on BYTE_SENT -> S2.
  - S2 WAIT_ACK1: READ_ENABLE=1; BYTE_READY with byte 0xFA and error 00 -> S3; any other byte or nonzero error -> RESTART.
  - S3 WAIT_BAT: as S2, expecting 0xAA -> S4.
  - S4 WAIT_ID: as S2, expecting 0x00 -> S5.
  - S5 SEND_EN: SEND_BYTE=1 for one cycle, BYTE_TO_SEND=0xF4 -> S6.
  - S6 WAIT_EN_SENT: on BYTE_SENT -> S7.
  - S7 WAIT_ACK2: as S2, expecting 0xFA -> S8.
  - S8 PKT0: INIT_DONE=1, READ_ENABLE=1; on good byte with bit3=1, latch into a shadow register -> S9. A byte with bit3=0 is discarded (resync) and the FSM stays in S8.
  - S9 PKT1: good byte -> shadow DX -> S10.
  - S10 PKT2: good byte -> MOUSE_STATUS/DX/DY all updated together from the shadow registers and this byte; SEND_INTERRUPT=1 on the following cycle; -> S8.
- **Error in S9/S10:** BYTE_ERROR_CODE≠00 drops the partial packet and returns to S8; MOUSE_* outputs are unchanged and no interrupt is raised.
- **Output atomicity:** MOUSE_* change only together, in the same cycle SEND_INTERRUPT rises.
- **RESTART action:** next state S0; RETRY_COUNT increments, saturating at 15; INIT_DONE=0.
- **Watchdog counting:**
  - Counts in S1–S4 and S6–S7.
  - Clears on every state change.
  - On reaching TIMEOUT_CYCLES-1 -> RESTART.
  - Inactive and held at 0 in S0, S5 and S8–S10.
- **Simultaneous events:** a BYTE_READY pulse in the same cycle as watchdog expiry is processed and the watchdog is ignored. BYTE_READY in S1/S6 is ignored (READ_ENABLE=0 there).
- **SEND_BYTE spacing:** SEND_BYTE never asserts on two consecutive cycles.

Test Plan:
- **Clean init:** release RESET; model answers BYTE_SENT, then 0xFA, 0xAA, 0x00; BYTE_SENT; 0xFA. Required: SEND_BYTE pulses with 0xFF then 0xF4; INIT_DONE=1 after the final ack; RETRY_COUNT=0.
- **Packet:** in streaming, feed 0x09, 0x05, 0xFB. Required: MOUSE_STATUS=0x09, MOUSE_DX=0x05, MOUSE_DY=0xFB; one SEND_INTERRUPT pulse one cycle after the third BYTE_READY.
- **Resync:** feed 0x00, then 0x08, 0x01, 0x02. Required: first byte discarded; one interrupt with STATUS=0x08, DX=0x01, DY=0x02.
- **Parity error mid-packet:** 0x08, then 0x10 with error=01, then 0x18, 0x03, 0x04. Required: no interrupt for the broken packet; next interrupt shows 0x18/0x03/0x04.
- **Bad ack / timeout:** with TIMEOUT_CYCLES=1000, respond 0xFE to 0xFF. Required: SEND_BYTE with 0xFF reissued; RETRY_COUNT=1. Then give no response. Required: restart exactly 1000 cycles after entering S1; RETRY_COUNT=2; saturation at 15 after 20 failures.
- **Reset mid-packet:** assert RESET for 1 cycle in S9. Required: outputs return to reset values; SEND_BYTE with 0xFF pulses again on the second cycle after RESET falls.

Source files
------------

// File: rtl/mouse_master_sm.sv
// PS/2 mouse host sequencer: runs the reset/enable handshake, then assembles
// 3-byte movement packets and flags each one with a one-cycle interrupt.
module mouse_master_sm #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic       BYTE_READY,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic [3:0] RETRY_COUNT,
  output logic [3:0] MASTER_STATE
);

  localparam logic [3:0] S0_SEND_RST      = 4'd0;
  localparam logic [3:0] S1_WAIT_RST_SENT = 4'd1;
  localparam logic [3:0] S2_WAIT_ACK1     = 4'd2;
  localparam logic [3:0] S3_WAIT_BAT      = 4'd3;
  localparam logic [3:0] S4_WAIT_ID       = 4'd4;
  localparam logic [3:0] S5_SEND_EN       = 4'd5;
  localparam logic [3:0] S6_WAIT_EN_SENT  = 4'd6;
  localparam logic [3:0] S7_WAIT_ACK2     = 4'd7;
  localparam logic [3:0] S8_PKT0          = 4'd8;
  localparam logic [3:0] S9_PKT1          = 4'd9;
  localparam logic [3:0] S10_PKT2         = 4'd10;

  localparam logic [26:0] WD_LAST = 27'(TIMEOUT_CYCLES - 1);

  logic [3:0]  r_state;
  logic [26:0] r_wd;
  logic [3:0]  r_retry;
  logic [7:0]  r_shadow_status;
  logic [7:0]  r_shadow_dx;
  logic        r_send_byte;
  logic [7:0]  r_byte_to_send;
  logic        r_read_enable;
  logic        r_init_done;
  logic        r_send_interrupt;
  logic [7:0]  r_mouse_status;
  logic [7:0]  r_mouse_dx;
  logic [7:0]  r_mouse_dy;

  logic [3:0]  w_next;
  logic        w_restart;
  logic [7:0]  w_expect;
  logic        w_good;
  logic        w_wd_active;
  logic        w_wd_expired;

  assign w_good       = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign w_wd_active  = r_state inside {S1_WAIT_RST_SENT, S2_WAIT_ACK1, S3_WAIT_BAT,
                                        S4_WAIT_ID, S6_WAIT_EN_SENT, S7_WAIT_ACK2};
  assign w_wd_expired = w_wd_active && (r_wd == WD_LAST);

  // A device event arriving on the expiry cycle wins over the watchdog.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next    = r_state;
    w_restart = 1'b0;
    w_expect  = 8'hFA;
    case (r_state)
      S3_WAIT_BAT: w_expect = 8'hAA;
      S4_WAIT_ID:  w_expect = 8'h00;
      default:     w_expect = 8'hFA;
    endcase

    case (r_state)
      S0_SEND_RST: w_next = S1_WAIT_RST_SENT;
      S1_WAIT_RST_SENT, S6_WAIT_EN_SENT: begin
        if (BYTE_SENT)         w_next = r_state + 4'd1;
        else if (w_wd_expired) w_restart = 1'b1;
      end
      S2_WAIT_ACK1, S3_WAIT_BAT, S4_WAIT_ID, S7_WAIT_ACK2: begin
        if (BYTE_READY) begin
          if (w_good && (BYTE_READ == w_expect)) w_next = r_state + 4'd1;
          else                                   w_restart = 1'b1;
        end else if (w_wd_expired) begin
          w_restart = 1'b1;
        end
      end
      S5_SEND_EN: w_next = S6_WAIT_EN_SENT;
      S8_PKT0:    if (w_good && BYTE_READ[3]) w_next = S9_PKT1;
      S9_PKT1:    if (BYTE_READY) w_next = w_good ? S10_PKT2 : S8_PKT0;
      S10_PKT2:   if (BYTE_READY) w_next = S8_PKT0;
      default:    w_next = S0_SEND_RST;
    endcase

    if (w_restart) w_next = S0_SEND_RST;
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (RESET) begin
      r_state          <= S0_SEND_RST;
      r_wd             <= '0;
      r_retry          <= '0;
      r_shadow_status  <= '0;
      r_shadow_dx      <= '0;
      r_send_byte      <= 1'b0;
      r_byte_to_send   <= '0;
      r_read_enable    <= 1'b0;
      r_init_done      <= 1'b0;
      r_send_interrupt <= 1'b0;
      r_mouse_status   <= '0;
      r_mouse_dx       <= '0;
      r_mouse_dy       <= '0;
    end else begin
      r_state          <= w_next;
      r_send_byte      <= (r_state == S0_SEND_RST) || (r_state == S5_SEND_EN);
      r_read_enable    <= w_next inside {S2_WAIT_ACK1, S3_WAIT_BAT, S4_WAIT_ID,
                                         S7_WAIT_ACK2, S8_PKT0, S9_PKT1, S10_PKT2};
      r_init_done      <= w_next inside {S8_PKT0, S9_PKT1, S10_PKT2};
      r_send_interrupt <= 1'b0;

      if (r_state == S0_SEND_RST) r_byte_to_send <= 8'hFF;
      if (r_state == S5_SEND_EN)  r_byte_to_send <= 8'hF4;

      if (w_restart && (r_retry != 4'hF)) r_retry <= r_retry + 4'd1;

      if (!w_wd_active || (w_next != r_state)) r_wd <= '0;
      else                                     r_wd <= r_wd + 27'd1;

      if ((r_state == S8_PKT0) && (w_next == S9_PKT1))  r_shadow_status <= BYTE_READ;
      if ((r_state == S9_PKT1) && (w_next == S10_PKT2)) r_shadow_dx     <= BYTE_READ;

      // The packet is published atomically with its interrupt.
      if ((r_state == S10_PKT2) && w_good) begin
        r_mouse_status   <= r_shadow_status;
        r_mouse_dx       <= r_shadow_dx;
        r_mouse_dy       <= BYTE_READ;
        r_send_interrupt <= 1'b1;
      end
    end
  end

  assign SEND_BYTE      = r_send_byte;
  assign BYTE_TO_SEND   = r_byte_to_send;
  assign READ_ENABLE    = r_read_enable;
  assign MOUSE_STATUS   = r_mouse_status;
  assign MOUSE_DX       = r_mouse_dx;
  assign MOUSE_DY       = r_mouse_dy;
  assign SEND_INTERRUPT = r_send_interrupt;
  assign INIT_DONE      = r_init_done;
  assign RETRY_COUNT    = r_retry;
  assign MASTER_STATE   = r_state;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed bench for mouse_master_sm: init handshake, packet vectors,
// reset mid-packet, bad ack, watchdog timing and retry saturation.
module tb_mouse_master_sm;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic       BYTE_READY = 1'b0;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic       INIT_DONE;
  logic [3:0] RETRY_COUNT;
  logic [3:0] MASTER_STATE;

  int n_total = 0;
  int n_bad   = 0;

  mouse_master_sm #(.TIMEOUT_CYCLES(1000)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .SEND_BYTE      (SEND_BYTE),
    .BYTE_TO_SEND   (BYTE_TO_SEND),
    .BYTE_SENT      (BYTE_SENT),
    .READ_ENABLE    (READ_ENABLE),
    .BYTE_READ      (BYTE_READ),
    .BYTE_READY     (BYTE_READY),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .MOUSE_STATUS   (MOUSE_STATUS),
    .MOUSE_DX       (MOUSE_DX),
    .MOUSE_DY       (MOUSE_DY),
    .SEND_INTERRUPT (SEND_INTERRUPT),
    .INIT_DONE      (INIT_DONE),
    .RETRY_COUNT    (RETRY_COUNT),
    .MASTER_STATE   (MASTER_STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic [1:0] err;
    logic       irq;
    logic [7:0] st;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [3:0] state;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_send(input logic [7:0] exp_byte, input string name);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      if (SEND_BYTE === 1'b1) begin
        found = 1;
        break;
      end
      tick();
    end
    check({name, "_seen"}, 32'(found), 32'd1);
    check({name, "_byte"}, 32'(BYTE_TO_SEND), 32'(exp_byte));
    tick();
    check({name, "_one_cycle"}, 32'(SEND_BYTE), 32'd0);
  endtask

  task automatic pulse_sent();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input logic [1:0] e);
    BYTE_READ       = b;
    BYTE_ERROR_CODE = e;
    BYTE_READY      = 1'b1;
    tick();
    BYTE_READY      = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    // data, err, irq, status, dx, dy, state after the byte
    vecs.push_back('{8'h09, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 4'd9});
    vecs.push_back('{8'h05, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 4'd10});
    vecs.push_back('{8'hFB, 2'b00, 1'b1, 8'h09, 8'h05, 8'hFB, 4'd8});
    vecs.push_back('{8'h00, 2'b00, 1'b0, 8'h09, 8'h05, 8'hFB, 4'd8});
    vecs.push_back('{8'h08, 2'b00, 1'b0, 8'h09, 8'h05, 8'hFB, 4'd9});
    vecs.push_back('{8'h01, 2'b00, 1'b0, 8'h09, 8'h05, 8'hFB, 4'd10});
    vecs.push_back('{8'h02, 2'b00, 1'b1, 8'h08, 8'h01, 8'h02, 4'd8});
    vecs.push_back('{8'h08, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02, 4'd9});
    vecs.push_back('{8'h10, 2'b01, 1'b0, 8'h08, 8'h01, 8'h02, 4'd8});
    vecs.push_back('{8'h18, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02, 4'd9});
    vecs.push_back('{8'h03, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02, 4'd10});
    vecs.push_back('{8'h04, 2'b00, 1'b1, 8'h18, 8'h03, 8'h04, 4'd8});
    vecs.push_back('{8'h28, 2'b00, 1'b0, 8'h18, 8'h03, 8'h04, 4'd9});
    vecs.push_back('{8'h05, 2'b00, 1'b0, 8'h18, 8'h03, 8'h04, 4'd10});
    vecs.push_back('{8'h06, 2'b10, 1'b0, 8'h18, 8'h03, 8'h04, 4'd8});
    vecs.push_back('{8'h08, 2'b01, 1'b0, 8'h18, 8'h03, 8'h04, 4'd8});
    vecs.push_back('{8'h19, 2'b00, 1'b0, 8'h18, 8'h03, 8'h04, 4'd9});

    // Reset state
    tick(); tick(); tick();
    check("rst_send_byte", 32'(SEND_BYTE), 32'd0);
    check("rst_byte_to_send", 32'(BYTE_TO_SEND), 32'h00);
    check("rst_read_enable", 32'(READ_ENABLE), 32'd0);
    check("rst_irq", 32'(SEND_INTERRUPT), 32'd0);
    check("rst_init_done", 32'(INIT_DONE), 32'd0);
    check("rst_retry", 32'(RETRY_COUNT), 32'd0);
    check("rst_state", 32'(MASTER_STATE), 32'd0);

    // Clean init
    RESET = 1'b0;
    wait_send(8'hFF, "init_ff");
    check("init_s1_state", 32'(MASTER_STATE), 32'd1);
    check("init_s1_read_en", 32'(READ_ENABLE), 32'd0);
    check("init_ff_held", 32'(BYTE_TO_SEND), 32'hFF);
    pulse_sent();
    check("init_s2_read_en", 32'(READ_ENABLE), 32'd1);
    feed(8'hFA, 2'b00);
    check("init_s3_state", 32'(MASTER_STATE), 32'd3);
    feed(8'hAA, 2'b00);
    check("init_s4_state", 32'(MASTER_STATE), 32'd4);
    feed(8'h00, 2'b00);
    wait_send(8'hF4, "init_f4");
    check("init_s6_state", 32'(MASTER_STATE), 32'd6);
    check("init_f4_held", 32'(BYTE_TO_SEND), 32'hF4);
    pulse_sent();
    check("init_s7_done", 32'(INIT_DONE), 32'd0);
    feed(8'hFA, 2'b00);
    check("init_done", 32'(INIT_DONE), 32'd1);
    check("init_state", 32'(MASTER_STATE), 32'd8);
    check("init_retry", 32'(RETRY_COUNT), 32'd0);

    // Packet vectors: packet, resync, parity error, errors in S10/S8
    foreach (vecs[i]) begin
      feed(vecs[i].data, vecs[i].err);
      check($sformatf("vec%0d_irq", i), 32'(SEND_INTERRUPT), 32'(vecs[i].irq));
      check($sformatf("vec%0d_status", i), 32'(MOUSE_STATUS), 32'(vecs[i].st));
      check($sformatf("vec%0d_dx", i), 32'(MOUSE_DX), 32'(vecs[i].dx));
      check($sformatf("vec%0d_dy", i), 32'(MOUSE_DY), 32'(vecs[i].dy));
      check($sformatf("vec%0d_state", i), 32'(MASTER_STATE), 32'(vecs[i].state));
      tick();
      check($sformatf("vec%0d_irq_off", i), 32'(SEND_INTERRUPT), 32'd0);
      check($sformatf("vec%0d_streaming", i), 32'(INIT_DONE), 32'd1);
    end

    // Reset for one cycle while in S9
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("mid_rst_state", 32'(MASTER_STATE), 32'd0);
    check("mid_rst_send", 32'(SEND_BYTE), 32'd0);
    check("mid_rst_byte", 32'(BYTE_TO_SEND), 32'h00);
    check("mid_rst_read_en", 32'(READ_ENABLE), 32'd0);
    check("mid_rst_status", 32'(MOUSE_STATUS), 32'h00);
    check("mid_rst_dx", 32'(MOUSE_DX), 32'h00);
    check("mid_rst_dy", 32'(MOUSE_DY), 32'h00);
    check("mid_rst_done", 32'(INIT_DONE), 32'd0);
    check("mid_rst_retry", 32'(RETRY_COUNT), 32'd0);
    tick();
    check("mid_rst_send2", 32'(SEND_BYTE), 32'd1);
    check("mid_rst_byte2", 32'(BYTE_TO_SEND), 32'hFF);
    tick();
    check("mid_rst_send3", 32'(SEND_BYTE), 32'd0);

    // BYTE_READY in S1 is ignored; then a bad ack restarts
    feed(8'hFA, 2'b00);
    check("s1_ignore_ready", 32'(MASTER_STATE), 32'd1);
    pulse_sent();
    feed(8'hFE, 2'b00);
    check("bad_ack_state", 32'(MASTER_STATE), 32'd0);
    check("bad_ack_retry", 32'(RETRY_COUNT), 32'd1);

    // No response: watchdog restarts 1000 cycles after entering S1
    wait_send(8'hFF, "reissue_ff");
    n = 1;
    while (MASTER_STATE != 4'd0 && n < 1100) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd1000);
    check("timeout_retry", 32'(RETRY_COUNT), 32'd2);

    // 18 more bad acks (one with an error code) take the count past saturation
    for (int k = 3; k <= 20; k++) begin
      wait_send(8'hFF, $sformatf("retry%0d_ff", k));
      pulse_sent();
      if (k == 10) feed(8'hFA, 2'b01);
      else         feed(8'hFE, 2'b00);
      check($sformatf("retry%0d_count", k), 32'(RETRY_COUNT), 32'((k > 15) ? 15 : k));
    end
    check("retry_saturated", 32'(RETRY_COUNT), 32'd15);
    check("retry_init_done", 32'(INIT_DONE), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
